// File: rtl/trace_command_sequencer_if.sv
// Bundle between the trace record source, the sequencer and the L2 model:
// record input, L1/snoop/control dispatch channels and status/statistics.
interface trace_command_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int CMD_W  = 4,
  parameter int CNT_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [CMD_W-1:0]  in_command;
  logic [ADDR_W-1:0] in_address;
  logic              in_last;

  logic              l1_valid;
  logic              l1_ready;
  logic [1:0]        l1_op;
  logic [ADDR_W-1:0] l1_address;

  logic              snp_valid;
  logic              snp_ready;
  logic [1:0]        snp_op;
  logic [ADDR_W-1:0] snp_address;

  logic              ctl_valid;
  logic              ctl_ready;
  logic [1:0]        ctl_op;

  logic              err_unknown;
  logic              done;
  logic [CNT_W-1:0]  cnt_l1;
  logic [CNT_W-1:0]  cnt_snoop;
  logic [CNT_W-1:0]  cnt_ctl;
  logic [CNT_W-1:0]  cnt_bad;

  modport master (
    input  in_valid, in_command, in_address, in_last, l1_ready, snp_ready, ctl_ready,
    output in_ready, l1_valid, l1_op, l1_address, snp_valid, snp_op, snp_address,
           ctl_valid, ctl_op, err_unknown, done, cnt_l1, cnt_snoop, cnt_ctl, cnt_bad
  );

  modport slave (
    output in_valid, in_command, in_address, in_last, l1_ready, snp_ready, ctl_ready,
    input  in_ready, l1_valid, l1_op, l1_address, snp_valid, snp_op, snp_address,
           ctl_valid, ctl_op, err_unknown, done, cnt_l1, cnt_snoop, cnt_ctl, cnt_bad
  );
endinterface

// File: rtl/trace_command_sequencer.sv
// Buffers trace records in a FIFO and dispatches them in order onto the L1, snoop
// or control channel through a single registered output slot; ends with a STATS op.
module trace_command_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int CMD_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input logic                       clock,
  input logic                       reset,
  trace_command_sequencer_if.master bus
);
  localparam int         PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         OCC_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] CTL_STATS = 2'b10;

  typedef enum logic [1:0] {RUN, FINAL, DONE} state_t;
  typedef enum logic [1:0] {CH_L1, CH_SNP, CH_CTL, CH_BAD} chan_t;
  typedef struct packed {
    chan_t      ch;
    logic [1:0] op;
  } dec_t;

  function automatic dec_t decode(input logic [CMD_W-1:0] cmd);
    dec_t d;
    d.ch = CH_BAD;
    d.op = 2'b00;
    if (cmd < CMD_W'(3)) begin
      d.ch = CH_L1;
      d.op = 2'(cmd);
    end else if (cmd < CMD_W'(7)) begin
      d.ch = CH_SNP;
      d.op = 2'(cmd - CMD_W'(3));
    end else if (cmd == CMD_W'(8) || cmd == CMD_W'(9)) begin
      d.ch = CH_CTL;
      d.op = 2'(cmd - CMD_W'(8));
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t            state;
  logic [CMD_W-1:0]  cmd_mem  [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic              last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  count, count_nx;
  logic              l1_hs, snp_hs, ctl_hs, stats_hs;
  logic              slot_free, push, pop;
  dec_t              head_p0;

  always_comb begin
    l1_hs     = bus.l1_valid && bus.l1_ready;
    snp_hs    = bus.snp_valid && bus.snp_ready;
    ctl_hs    = bus.ctl_valid && bus.ctl_ready;
    stats_hs  = ctl_hs && (bus.ctl_op == CTL_STATS);
    slot_free = !(bus.l1_valid || bus.snp_valid || bus.ctl_valid) || l1_hs || snp_hs || ctl_hs;
    push      = bus.in_valid && bus.in_ready;
    pop       = (state == RUN) && slot_free && (count != '0);
    head_p0   = decode(cmd_mem[rd_ptr]);
    count_nx  = count + OCC_W'(push) - OCC_W'(pop);
  end

  // p0: record storage
  always_ff @(posedge clock) begin
    if (push) begin
      cmd_mem[wr_ptr]  <= bus.in_command;
      addr_mem[wr_ptr] <= bus.in_address;
      last_mem[wr_ptr] <= bus.in_last;
    end
  end

  // p1: output slot, sequencing FSM and statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= RUN;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.in_ready    <= 1'b1;
      bus.l1_valid    <= 1'b0;
      bus.l1_op       <= '0;
      bus.l1_address  <= '0;
      bus.snp_valid   <= 1'b0;
      bus.snp_op      <= '0;
      bus.snp_address <= '0;
      bus.ctl_valid   <= 1'b0;
      bus.ctl_op      <= '0;
      bus.err_unknown <= 1'b0;
      bus.done        <= 1'b0;
      bus.cnt_l1      <= '0;
      bus.cnt_snoop   <= '0;
      bus.cnt_ctl     <= '0;
      bus.cnt_bad     <= '0;
    end else begin
      bus.err_unknown <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count        <= count_nx;
      // in_ready is precomputed from next occupancy so no ready input reaches it combinationally
      bus.in_ready <= (count_nx != OCC_W'(FIFO_DEPTH)) && !stats_hs && (state != DONE);

      if (l1_hs) begin
        bus.l1_valid <= 1'b0;
        bus.cnt_l1   <= sat_inc(bus.cnt_l1);
      end
      if (snp_hs) begin
        bus.snp_valid <= 1'b0;
        bus.cnt_snoop <= sat_inc(bus.cnt_snoop);
      end
      if (ctl_hs) begin
        bus.ctl_valid <= 1'b0;
        if (!stats_hs) bus.cnt_ctl <= sat_inc(bus.cnt_ctl);
      end

      case (state)
        RUN: begin
          if (pop) begin
            case (head_p0.ch)
              CH_L1: begin
                bus.l1_valid   <= 1'b1;
                bus.l1_op      <= head_p0.op;
                bus.l1_address <= addr_mem[rd_ptr];
              end
              CH_SNP: begin
                bus.snp_valid   <= 1'b1;
                bus.snp_op      <= head_p0.op;
                bus.snp_address <= addr_mem[rd_ptr];
              end
              CH_CTL: begin
                bus.ctl_valid <= 1'b1;
                bus.ctl_op    <= head_p0.op;
              end
              default: begin
                bus.err_unknown <= 1'b1;
                bus.cnt_bad     <= sat_inc(bus.cnt_bad);
              end
            endcase
            if (last_mem[rd_ptr]) state <= FINAL;
          end
        end
        FINAL: begin
          // The slot frees only once the last record has completed, so STATS trails it
          if (stats_hs) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else if (slot_free) begin
            bus.ctl_valid <= 1'b1;
            bus.ctl_op    <= CTL_STATS;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_trace_command_sequencer.sv
// Directed bench for trace_command_sequencer: an in-order scoreboard of expected
// channel transactions checked every cycle, plus hand-computed literal checks.
module tb_trace_command_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trace_command_sequencer_if #(.ADDR_W(32), .CMD_W(4), .CNT_W(32)) bus ();

  trace_command_sequencer #(
    .ADDR_W(32), .CMD_W(4), .FIFO_DEPTH(4), .CNT_W(32)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  // kind: 0 L1, 1 snoop, 2 control, 3 unknown (dropped)
  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  op;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_l1 = 0, m_snp = 0, m_ctl = 0, m_bad = 0;
  logic m_done = 1'b0;
  logic mon_en = 1'b0;
  logic prev_hold = 1'b0;

  logic [3:0]  t3c [6] = '{4'd0, 4'd3, 4'd8, 4'd1, 4'd6, 4'd2};
  logic [31:0] t3a [6] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  function automatic exp_t model_of(input logic [3:0] c, input logic [31:0] a);
    exp_t e;
    int   v;
    v = int'(c);
    if (v <= 2)                e = '{2'd0, 2'(v), a};
    else if (v <= 6)           e = '{2'd1, 2'(v - 3), a};
    else if (v == 8 || v == 9) e = '{2'd2, 2'(v - 8), 32'h0};
    else                       e = '{2'd3, 2'd0, 32'h0};
    return e;
  endfunction

  task automatic model_push(input logic [3:0] c, input logic [31:0] a, input logic l);
    exp_q.push_back(model_of(c, a));
    if (l) exp_q.push_back('{2'd2, 2'd2, 32'h0});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    mon_en = 1'b0;
    rst    = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_l1 = 0; m_snp = 0; m_ctl = 0; m_bad = 0;
    m_done = 1'b0; prev_hold = 1'b0;
    mon_en = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [3:0] c, input logic [31:0] a, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_command = c; bus.in_address = a; bus.in_last = l;
    while (!bus.in_ready && n < 100) begin cyc(); n++; end
    if (bus.in_ready) begin
      @(posedge clk);
      model_push(c, a, l);
      #1;
    end else check("push_timeout", 1, 0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  always @(negedge clk) begin
    int          nv;
    logic [1:0]  ak, aop;
    logic [31:0] aaddr;
    logic        hs;
    if (mon_en) begin
      nv = int'(bus.l1_valid) + int'(bus.snp_valid) + int'(bus.ctl_valid);
      check("one_valid", nv <= 1, 1);
      if (bus.err_unknown) begin
        if (exp_q.size() == 0) check("err_unexpected", 1, 0);
        else begin
          check("err_order", exp_q[0].kind, 2'd3);
          if (exp_q[0].kind == 2'd3) m_bad++;
          void'(exp_q.pop_front());
        end
      end
      check("cnt_l1", bus.cnt_l1, m_l1);
      check("cnt_snoop", bus.cnt_snoop, m_snp);
      check("cnt_ctl", bus.cnt_ctl, m_ctl);
      check("cnt_bad", bus.cnt_bad, m_bad);
      check("done", bus.done, m_done);
      if (m_done) begin
        check("in_ready_done", bus.in_ready, 0);
        check("idle_done", nv, 0);
      end
      if (prev_hold) check("no_retract", nv, 1);
      hs = 1'b0; ak = 2'd0; aop = 2'd0; aaddr = 32'h0;
      if (nv == 1) begin
        if (bus.l1_valid) begin
          ak = 2'd0; aop = bus.l1_op; aaddr = bus.l1_address; hs = bus.l1_ready;
        end else if (bus.snp_valid) begin
          ak = 2'd1; aop = bus.snp_op; aaddr = bus.snp_address; hs = bus.snp_ready;
        end else begin
          ak = 2'd2; aop = bus.ctl_op; aaddr = 32'h0; hs = bus.ctl_ready;
        end
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          check("order_kind", ak, exp_q[0].kind);
          check("order_op", aop, exp_q[0].op);
          check("order_addr", aaddr, exp_q[0].addr);
          if (hs) begin
            case (exp_q[0].kind)
              2'd0: m_l1++;
              2'd1: m_snp++;
              2'd2: if (exp_q[0].op == 2'd2) m_done = 1'b1; else m_ctl++;
              default: ;
            endcase
            void'(exp_q.pop_front());
          end
        end
      end
      prev_hold = (nv == 1) && !hs;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n, acc, errc;
    logic seen_print, seen_w, seen_stats;
    bus.in_valid = 0; bus.in_command = 0; bus.in_address = 0; bus.in_last = 0;
    bus.l1_ready = 0; bus.snp_ready = 0; bus.ctl_ready = 0;
    do_reset(3);

    // Reset state
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_l1_valid", bus.l1_valid, 0);
    check("rst_snp_valid", bus.snp_valid, 0);
    check("rst_ctl_valid", bus.ctl_valid, 0);
    check("rst_err", bus.err_unknown, 0);
    check("rst_ops", {bus.l1_op, bus.snp_op, bus.ctl_op}, 0);
    check("rst_addr", {bus.l1_address, bus.snp_address}, 0);

    // Test 1: three L1 records back to back
    cyc();
    bus.l1_ready = 1;
    check("t1_in_ready", bus.in_ready, 1);
    bus.in_valid = 1; bus.in_command = 0; bus.in_address = 32'h1000;
    @(posedge clk); model_push(4'd0, 32'h1000, 1'b0); #1;
    bus.in_command = 1; bus.in_address = 32'h2000;
    @(negedge clk); check("t1_lat0", bus.l1_valid, 0);
    @(posedge clk); model_push(4'd1, 32'h2000, 1'b0); #1;
    bus.in_command = 2; bus.in_address = 32'h3000;
    @(negedge clk);
    check("t1_v0", bus.l1_valid, 1); check("t1_op0", bus.l1_op, 2'b00); check("t1_a0", bus.l1_address, 32'h1000);
    @(posedge clk); model_push(4'd2, 32'h3000, 1'b0); #1;
    bus.in_valid = 0;
    @(negedge clk);
    check("t1_v1", bus.l1_valid, 1); check("t1_op1", bus.l1_op, 2'b01); check("t1_a1", bus.l1_address, 32'h2000);
    @(negedge clk);
    check("t1_v2", bus.l1_valid, 1); check("t1_op2", bus.l1_op, 2'b10); check("t1_a2", bus.l1_address, 32'h3000);
    @(negedge clk);
    check("t1_idle", bus.l1_valid, 0); check("t1_cnt", bus.cnt_l1, 3);

    // Test 2: snoop held while ready low
    cyc();
    push(4'd4, 32'hABCD, 1'b0);
    n = 0;
    @(negedge clk);
    while (!bus.snp_valid && n < 20) begin @(negedge clk); n++; end
    check("t2_seen", bus.snp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("t2_hold_valid", bus.snp_valid, 1);
      check("t2_hold_op", bus.snp_op, 2'b01);
      check("t2_hold_addr", bus.snp_address, 32'hABCD);
      check("t2_hold_cnt", bus.cnt_snoop, 0);
    end
    cyc();
    bus.snp_ready = 1;
    @(posedge clk); #1 bus.snp_ready = 0;
    @(negedge clk);
    check("t2_cnt", bus.cnt_snoop, 1); check("t2_released", bus.snp_valid, 0);

    // Test 3: fill FIFO plus slot with every ready low
    cyc();
    bus.l1_ready = 0; bus.snp_ready = 0; bus.ctl_ready = 0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1; bus.in_command = t3c[i]; bus.in_address = t3a[i]; bus.in_last = 0;
      if (bus.in_ready) begin
        @(posedge clk); model_push(t3c[i], t3a[i], 1'b0); acc++; #1;
      end
    end
    check("t3_accepts", acc, 5);
    for (int i = 0; i < 3; i++) begin
      check("t3_full", bus.in_ready, 0);
      cyc();
    end
    bus.l1_ready = 1; bus.snp_ready = 1; bus.ctl_ready = 1;
    push(t3c[5], t3a[5], 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin cyc(); n++; end
    check("t3_drain", exp_q.size(), 0);

    // Test 4: unknown command then PRINT
    push(4'd7, 32'h10, 1'b0);
    push(4'd9, 32'h20, 1'b0);
    errc = 0; seen_print = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.err_unknown) errc++;
      if (bus.ctl_valid && bus.ctl_op == 2'b01) seen_print = 1;
    end
    check("t4_err_pulse", errc, 1);
    check("t4_print", seen_print, 1);
    check("t4_cnt_bad", bus.cnt_bad, 1);
    check("t4_cnt_ctl", bus.cnt_ctl, 2);

    // Test 5: last record, STATS, done
    cyc();
    push(4'd5, 32'h40, 1'b1);
    seen_w = 0; seen_stats = 0; n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      if (bus.snp_valid && bus.snp_op == 2'b10 && bus.snp_address == 32'h40) seen_w = 1;
      if (bus.ctl_valid && bus.ctl_op == 2'b10) seen_stats = 1;
      n++;
    end
    check("t5_snoop_w", seen_w, 1);
    check("t5_stats", seen_stats, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_done", bus.done, 1);
      check("t5_in_ready", bus.in_ready, 0);
    end
    check("t5_tot_l1", bus.cnt_l1, 6);
    check("t5_tot_snoop", bus.cnt_snoop, 4);
    check("t5_tot_ctl", bus.cnt_ctl, 2);
    check("t5_tot_bad", bus.cnt_bad, 1);

    // Test 6: reset while a snoop is waiting
    do_reset(1);
    bus.l1_ready = 1; bus.snp_ready = 0; bus.ctl_ready = 0;
    push(4'd0, 32'h70, 1'b0);
    push(4'd3, 32'h50, 1'b0);
    push(4'd4, 32'h60, 1'b0);
    n = 0;
    @(negedge clk);
    while (!bus.snp_valid && n < 20) begin @(negedge clk); n++; end
    check("t6_waiting", bus.snp_valid, 1);
    check("t6_pre_cnt", bus.cnt_l1, 1);
    do_reset(1);
    bus.snp_ready = 1; bus.ctl_ready = 1;
    @(negedge clk);
    check("t6_valids", {bus.l1_valid, bus.snp_valid, bus.ctl_valid}, 0);
    check("t6_cnt_l1", bus.cnt_l1, 0);
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_done", bus.done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_fifo_empty", {bus.l1_valid, bus.snp_valid, bus.ctl_valid, bus.err_unknown}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
